// File: rtl/obi_bram_arbiter.sv
// obi_bram_arbiter
//   Lets the core's OBI instruction port (read-only) and OBI data port (read/write)
//   share one simple-dual-port, byte-write BRAM (port A writes, port B reads).
//   A data write on port A can proceed in the same cycle as one read on port B.
//   Two competing reads are arbitrated round-robin.
//   Responses come back in order with a fixed latency of READ_LATENCY cycles.
//
// Ports
//   clk_i, rst_ni            clock; synchronous active-low reset
//   instr_*                  OBI instruction port: req/addr in; gnt/rvalid/rdata out
//   data_*                   OBI data port: req/we/be/addr/wdata in; gnt/rvalid/rdata out
//   ram_addra_o/dina_o/wea_o BRAM write port A
//   ram_addrb_o/enb_o        BRAM read port B
//   ram_rstb_o/regceb_o      BRAM output-register reset and clock enable
//   ram_doutb_i              BRAM read data
module obi_bram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  output logic [31:0]           ram_dina_o,
  output logic [3:0]            ram_wea_o,
  output logic [ADDR_WIDTH-1:0] ram_addrb_o,
  output logic                  ram_enb_o,
  output logic                  ram_rstb_o,
  output logic                  ram_regceb_o,
  input  logic [31:0]           ram_doutb_i
);

  // rr_last records which port won the most recent contested read.
  typedef enum logic {RR_DATA = 1'b0, RR_INSTR = 1'b1} rr_e;

  rr_e rr_last_q, rr_last_d;

  logic [READ_LATENCY-1:0] ivld_q, ivld_d;   // instruction response valid pipeline
  logic [READ_LATENCY-1:0] dvld_q, dvld_d;   // data response valid pipeline
  logic [READ_LATENCY-1:0] drd_q,  drd_d;    // data response is a read (carries rdata)

  logic instr_gnt, data_gnt;
  logic data_rd, data_wr;

  logic [ADDR_WIDTH-1:0] instr_word, data_word;

  // Address bits outside the word index are ignored; higher bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0],
                              data_addr_i[31:ADDR_WIDTH+2],  data_addr_i[1:0]};

  assign instr_word = instr_addr_i[ADDR_WIDTH+1:2];
  assign data_word  = data_addr_i[ADDR_WIDTH+1:2];
  assign data_rd    = data_req_i & ~data_we_i;
  assign data_wr    = data_req_i &  data_we_i;

  // Grant decision: combinational from requests and rr_last.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    rr_last_d = rr_last_q;
    if (rst_ni) begin
      if (data_wr) begin
        // The write uses port A, so port B is free for an instruction fetch.
        data_gnt  = 1'b1;
        instr_gnt = instr_req_i;
      end else if (data_rd && instr_req_i) begin
        if (rr_last_q == RR_INSTR) begin
          data_gnt  = 1'b1;
          rr_last_d = RR_DATA;
        end else begin
          instr_gnt = 1'b1;
          rr_last_d = RR_INSTR;
        end
      end else begin
        data_gnt  = data_rd;
        instr_gnt = instr_req_i;
      end
    end
  end

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  assign ram_addra_o = data_word;
  assign ram_dina_o  = data_wdata_i;
  assign ram_wea_o   = (data_gnt && data_wr) ? data_be_i : 4'b0000;
  assign ram_addrb_o = instr_gnt ? instr_word : data_word;
  assign ram_enb_o   = instr_gnt | (data_gnt & data_rd);

  // Response pipelines: stage 0 is loaded at grant time, and each cycle shifts it one stage along.
  always_comb begin
    ivld_d    = ivld_q;
    dvld_d    = dvld_q;
    drd_d     = drd_q;
    ivld_d[0] = instr_gnt;
    dvld_d[0] = data_gnt;
    drd_d[0]  = data_gnt & data_rd;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      ivld_d[i] = ivld_q[i-1];
      dvld_d[i] = dvld_q[i-1];
      drd_d[i]  = drd_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_last_q <= RR_INSTR;
      ivld_q    <= '0;
      dvld_q    <= '0;
      drd_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      ivld_q    <= ivld_d;
      dvld_q    <= dvld_d;
      drd_q     <= drd_d;
    end
  end

  // rvalid is also masked by the reset input, so a response due in the
  // reset cycle itself is dropped rather than delivered.
  assign instr_rvalid_o = ivld_q[READ_LATENCY-1] & rst_ni;
  assign data_rvalid_o  = dvld_q[READ_LATENCY-1] & rst_ni;
  assign instr_rdata_o  = instr_rvalid_o ? ram_doutb_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && drd_q[READ_LATENCY-1]) ? ram_doutb_i : 32'h0;

  // With an output register, load it one cycle after the read is issued.
  assign ram_regceb_o = (READ_LATENCY == 2) ? (ivld_q[0] | drd_q[0]) : 1'b0;
  assign ram_rstb_o   = ~rst_ni;

endmodule

// File: tb/tb_obi_bram_arbiter.sv
module tb_obi_bram_arbiter;

  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Shared stimulus
  logic        rst_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;

  // Instance 1: READ_LATENCY = 1
  logic          i_gnt1, i_rv1, d_gnt1, d_rv1, enb1, rstb1, regceb1;
  logic [31:0]   i_rd1, d_rd1, dina1, doutb1;
  logic [3:0]    wea1;
  logic [AW-1:0] addra1, addrb1;
  // Instance 2: READ_LATENCY = 2
  logic          i_gnt2, i_rv2, d_gnt2, d_rv2, enb2, rstb2, regceb2;
  logic [31:0]   i_rd2, d_rd2, dina2, doutb2;
  logic [3:0]    wea2;
  logic [AW-1:0] addra2, addrb2;

  obi_bram_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(i_gnt1),
    .instr_rvalid_o(i_rv1), .instr_rdata_o(i_rd1),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(d_gnt1),
    .data_rvalid_o(d_rv1), .data_rdata_o(d_rd1),
    .ram_addra_o(addra1), .ram_dina_o(dina1), .ram_wea_o(wea1),
    .ram_addrb_o(addrb1), .ram_enb_o(enb1), .ram_rstb_o(rstb1),
    .ram_regceb_o(regceb1), .ram_doutb_i(doutb1));

  obi_bram_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(i_gnt2),
    .instr_rvalid_o(i_rv2), .instr_rdata_o(i_rd2),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(d_gnt2),
    .data_rvalid_o(d_rv2), .data_rdata_o(d_rd2),
    .ram_addra_o(addra2), .ram_dina_o(dina2), .ram_wea_o(wea2),
    .ram_addrb_o(addrb2), .ram_enb_o(enb2), .ram_rstb_o(rstb2),
    .ram_regceb_o(regceb2), .ram_doutb_i(doutb2));

  // Behavioural BRAMs (read-first, optional output register)
  logic [31:0] bram1 [64];
  logic [31:0] bram2 [64];
  logic [31:0] raw2, oreg2;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wea1[b]) bram1[addra1][8*b +: 8] <= dina1[8*b +: 8];
      if (wea2[b]) bram2[addra2][8*b +: 8] <= dina2[8*b +: 8];
    end
    if (enb1) doutb1 <= bram1[addrb1];
    if (enb2) raw2 <= bram2[addrb2];
    if (rstb2) oreg2 <= '0;
    else if (regceb2) oreg2 <= raw2;
  end
  assign doutb2 = oreg2;

  // Reference model state
  logic [31:0] ref_mem [64];
  bit          last_instr = 1'b1;   // last contested winner was instr
  bit          prev_rd = 1'b0;
  bit          mon_en = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t q [4][$];   // 0: instr L1, 1: data L1, 2: instr L2, 3: data L2

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic mon_one(input int idx, input logic rv, input logic [31:0] rd);
    logic        ev;
    logic [31:0] ed;
    ev = (q[idx].size() > 0) && (q[idx][0].due == cyc);
    ed = ev ? q[idx][0].data : 32'h0;
    checks++;
    if (rv !== ev || rd !== ed) begin
      errors++;
      $display("FAIL rsp%0d cyc=%0d got v=%0b d=%h exp v=%0b d=%h", idx, cyc, rv, rd, ev, ed);
    end
    if (ev) void'(q[idx].pop_front());
    else if (q[idx].size() > 0 && q[idx][0].due < cyc) void'(q[idx].pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, i_rv1, i_rd1);
      mon_one(1, d_rv1, d_rd1);
      mon_one(2, i_rv2, i_rd2);
      mon_one(3, d_rv2, d_rd2);
    end
  end

  // One clock cycle of stimulus, with grant checks and model update
  task automatic step(input bit rn, input bit ir, input logic [31:0] ia, input bit dr,
                      input bit dw, input logic [3:0] be, input logic [31:0] da,
                      input logic [31:0] wd);
    bit         eig, edg, rd_g;
    logic [5:0] iw, dwi;
    logic [3:0] ewea;
    @(posedge clk);
    #1;
    rst_n = rn; instr_req = ir; instr_addr = ia; data_req = dr; data_we = dw;
    data_be = be; data_addr = da; data_wdata = wd;
    if (!rn) for (int k = 0; k < 4; k++) q[k].delete();
    @(negedge clk);
    eig = 1'b0;
    edg = 1'b0;
    if (!rn) begin
      last_instr = 1'b1;
    end else if (dr && dw) begin
      edg = 1'b1;
      eig = ir;
    end else if (dr && ir) begin
      if (last_instr) begin edg = 1'b1; last_instr = 1'b0; end
      else            begin eig = 1'b1; last_instr = 1'b1; end
    end else begin
      edg = dr;
      eig = ir;
    end
    rd_g = eig || (edg && !dw);
    ewea = (edg && dw) ? be : 4'h0;
    chk("instr_gnt_l1", {31'b0, i_gnt1}, {31'b0, eig});
    chk("data_gnt_l1",  {31'b0, d_gnt1}, {31'b0, edg});
    chk("instr_gnt_l2", {31'b0, i_gnt2}, {31'b0, eig});
    chk("data_gnt_l2",  {31'b0, d_gnt2}, {31'b0, edg});
    chk("enb_l1", {31'b0, enb1}, {31'b0, rd_g});
    chk("enb_l2", {31'b0, enb2}, {31'b0, rd_g});
    chk("wea_l1", {28'b0, wea1}, {28'b0, ewea});
    chk("wea_l2", {28'b0, wea2}, {28'b0, ewea});
    chk("rstb", {31'b0, rstb1}, {31'b0, !rn});
    chk("regceb_l1", {31'b0, regceb1}, 32'h0);
    chk("regceb_l2", {31'b0, regceb2}, {31'b0, prev_rd});
    prev_rd = rd_g;
    iw  = ia[7:2];
    dwi = da[7:2];
    if (eig) begin
      q[0].push_back('{cyc + 1, ref_mem[iw]});
      q[2].push_back('{cyc + 2, ref_mem[iw]});
    end
    if (edg) begin
      q[1].push_back('{cyc + 1, dw ? 32'h0 : ref_mem[dwi]});
      q[3].push_back('{cyc + 2, dw ? 32'h0 : ref_mem[dwi]});
      if (dw)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[dwi][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    mon_en = 1'b1;

    // Fill every word so the memories start from known contents
    for (int k = 0; k < 64; k++)
      step(1, 0, 0, 1, 1, 4'hF, k << 2, (k * 32'h01010101) ^ 32'h5A5A0000);
    idle(2);

    // Write then read
    step(1, 0, 0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    step(1, 0, 0, 1, 0, 4'h0, 32'h10, 0);
    idle(2);
    // Byte write, then read back the merged word
    step(1, 0, 0, 1, 1, 4'b0010, 32'h10, 32'h0000AA00);
    step(1, 0, 0, 1, 0, 4'h0, 32'h10, 0);
    idle(2);
    // Contested reads straight after reset
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 32'h4, 1, 0, 4'h0, 32'h10, 0);
    idle(3);
    // Parallel write and fetch of the same word
    step(1, 0, 0, 1, 1, 4'hF, 32'h20, 32'h11111111);
    step(1, 1, 32'h20, 1, 1, 4'hF, 32'h20, 32'h22222222);
    step(1, 1, 32'h20, 0, 0, 4'h0, 0, 0);
    idle(3);
    // Read followed by write: in-order responses and regceb timing
    step(1, 0, 0, 1, 0, 4'h0, 32'h10, 0);
    step(1, 0, 0, 1, 1, 4'hF, 32'h30, 32'hCAFEF00D);
    idle(4);
    // Reset the cycle after a read grant
    step(1, 1, 32'h20, 0, 0, 4'h0, 0, 0);
    step(0, 1, 32'h20, 1, 0, 4'h0, 32'h10, 0);
    step(1, 1, 32'h8, 1, 0, 4'h0, 32'h14, 0);
    idle(3);

    // Randomized traffic with aliasing addresses and occasional resets
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
           $urandom & 32'hF000_003F, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom & 32'hF000_003F, $urandom);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
